floo_wormhole_arbiter: RTL
==========================

// Module: floo_wormhole_arbiter
// PURPOSE
//  Output-port stage directly downstream of route selection. Each input port's route
//  selector asserts a one-hot request toward this output. This block arbitrates NumInp
//  requesters round-robin and locks the grant for a whole wormhole packet (head..last).
//  It then forwards flits to one output link. One instance per router output port.
// PARAMETERS
//  NumInp   default 5      number of requesting input ports (>=1)
//  flit_t   default logic  flit type; must contain hdr.last (1 = tail flit)
//  IdxWidth default $clog2(NumInp) (1 if NumInp==1)  width of the grant index
// PORTS
//  clk_i          in   1         clock, all state on posedge
//  rst_i          in   1         asynchronous reset, active-high
//  valid_i        in   NumInp    per-input valid (route_sel bit AND input valid)
//  ready_o        out  NumInp    per-input ready
//  data_i         in   NumInp    per-input flit (flit_t array)
//  valid_o        out  1         output flit valid
//  ready_i        in   1         downstream ready
//  data_o         out  flit_t    output flit
//  locked_o       out  1         1 while a multi-flit packet holds the output
//  gnt_idx_o      out  IdxWidth  index of the currently granted or locked input
// BEHAVIOUR
//  Reset (async, rst_i=1): lock_q=0, gnt_idx_q=0, rr_ptr_q=0. valid_o=0. ready_o=0.
//   data_o='0. locked_o=0.
//  Handshake: a transfer occurs when valid and ready are both high on a cycle edge.
//   A valid input must hold valid and data until it sees ready; the bench checks this.
//   ready_o[i] never combinationally depends on valid_o.
//  States: IDLE (lock_q=0) and LOCKED (lock_q=1).
//  IDLE:
//   - sel = first i with valid_i[i]=1, scanning rr_ptr_q, rr_ptr_q+1, ... mod NumInp.
//   - If any input is valid: valid_o=1, data_o=data_i[sel], ready_o[sel]=ready_i,
//     all other ready_o=0, gnt_idx_o=sel.
//   - If none is valid: valid_o=0, gnt_idx_o=gnt_idx_q.
//   - On a transfer with hdr.last=0: go to LOCKED with gnt_idx_q=sel.
//   - On a transfer with hdr.last=1 (single-flit packet): stay IDLE, rr_ptr_q=(sel+1)%NumInp.
//   - No transfer: no state change. The grant may move next cycle (combinational arbitration).
//  LOCKED:
//   - Only input gnt_idx_q is served: valid_o=valid_i[gnt_idx_q], ready_o[gnt_idx_q]=ready_i,
//     all other ready_o=0. Other requests are ignored even if valid.
//   - Locked input deasserts valid (bubble): valid_o=0, lock is held.
//   - Transfer with hdr.last=1: go to IDLE, rr_ptr_q=(gnt_idx_q+1)%NumInp.
//     A new arbitration is possible in the next cycle. Zero dead cycles between packets.
//  Latency: 0 cycles in the base build (combinational path data_i -> data_o).
//   Throughput is 1 flit/cycle.
//  Arithmetic: rr_ptr wraps modulo NumInp; not a power-of-two wrap (NumInp=5: 4 -> 0).
//  Reset mid-packet: the lock is dropped immediately and rr_ptr returns to 0.
//   Upstream residue of the packet is not tracked here.
//  NumInp==1: degenerates to wires plus lock tracking; rr_ptr stays 0.
// CONFIGURATION
//  Macro FLOO_WORMHOLE_ARB_OUT_REG_EN:
//   Defined: a one-entry output register is inserted after the mux.
//    - valid_o, data_o and locked_o come from flops.
//    - Internal ready = ~full_q | ready_i, giving full throughput with 1-cycle latency.
//    - Lock/rr updates happen on the internal (mux-to-register) transfer.
//    - The register resets empty: valid_o=0.
//   Undefined: the purely combinational output path described above.
// STRUCTURE
//  floo_pkg: add typedef arb_state_e {ArbIdle, ArbLocked}.
//  Shared by all users: floo_pkg helper function rr_next(ptr, n).
//  Sub-module floo_output_reg: the one-entry valid/ready pipeline register.
//   Instantiated only under FLOO_WORMHOLE_ARB_OUT_REG_EN.
//   Reusable on other router links.
//  Arbitration mux and rr logic stay local.
// TESTING (NumInp=5, base build unless stated)
//  1 Reset: hold rst_i=1 with all valid_i=1.
//    -> valid_o=0, ready_o=0.
//    -> First grant after release goes to input 0.
//  2 Round-robin: inputs 1 and 3 both send 1-flit packets continuously.
//    -> Output order is 1,3,1,3.
//    -> rr_ptr_q goes 2,4,2,4.
//  3 Wormhole lock: input 2 sends a 4-flit packet; input 0 is valid throughout.
//    -> Flits 2a..2d are contiguous on the output.
//    -> ready_o[0]=0 until 2d transfers.
//    -> Input 0 is granted on the next cycle.
//  4 Bubble and backpressure inside a packet:
//    - Input 4 drops valid for 2 cycles mid-packet.
//    - ready_i=0 for 3 cycles mid-packet.
//    -> locked_o stays 1 and gnt_idx_o=4.
//    -> No other input is granted; data_o is stable while ready_i=0.
//  5 Wrap and reset mid-packet:
//    - Grant input 4 with last=1 -> rr_ptr_q=0.
//    - Then assert rst_i during input 1's 3-flit packet.
//    -> After reset: locked_o=0, rr_ptr_q=0.
//  6 With FLOO_WORMHOLE_ARB_OUT_REG_EN:
//    -> Scenario 3 output is delayed 1 cycle with no gaps.
//    -> ready_i toggling 1010 loses and duplicates no flits.

Source files
------------

// File: rtl/floo_pkg.sv
// Shared router types and helpers: arbiter state encoding, default flit
// layout (header with tail marker plus payload) and the round-robin step.
package floo_pkg;

  typedef enum logic {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic last;  // 1 = tail flit of a packet
  } hdr_t;

  typedef struct packed {
    hdr_t       hdr;
    logic [7:0] payload;
  } flit_t;

  // Advance a round-robin pointer by one, wrapping at n (n need not be a power of two).
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/floo_wormhole_arbiter_if.sv
// Handshake bundle of one wormhole arbiter: NumInp requesting inputs and one
// output link. Signal names are written from the arbiter's point of view.
//
// Valid/ready semantics: a flit moves on a rising clock edge where valid and
// ready are both high. A source holding valid keeps valid and data unchanged
// until it sees ready; ready may be asserted independently of valid.
interface floo_wormhole_arbiter_if #(
  parameter int unsigned NumInp = 5,
  parameter type         flit_t = floo_pkg::flit_t
);
  logic  [NumInp-1:0] valid_i;
  logic  [NumInp-1:0] ready_o;
  flit_t [NumInp-1:0] data_i;
  logic               valid_o;
  logic               ready_i;
  flit_t              data_o;

  // Arbiter side
  modport slave (
    input  valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o
  );

  // Environment side (input ports upstream, link downstream)
  modport master (
    output valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o
  );
endinterface

// File: rtl/floo_wormhole_arbiter_output_reg.sv
// floo_output_reg: one-entry valid/ready pipeline register for a router link.
// Accepts a new item whenever it is empty or being drained in the same cycle,
// so it sustains one item per cycle at one cycle of latency.
module floo_output_reg #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic full_q, full_d;
  T     data_q, data_d;

  assign ready_o = ~full_q | ready_i;
  assign valid_o = full_q;
  assign data_o  = data_q;

  // Next-state: load on accept, otherwise empty when the consumer takes the item.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (valid_i && ready_o) begin
      full_d = 1'b1;
      data_d = data_i;
    end else if (ready_i) begin
      full_d = 1'b0;
    end
  end

  // Storage register, resets empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/floo_wormhole_arbiter.sv
// floo_wormhole_arbiter: round-robin arbiter for one router output port that
// locks its grant from the head flit to the tail flit of a wormhole packet.
// Optional build macro FLOO_WORMHOLE_ARB_OUT_REG_EN inserts a one-entry output
// register after the mux (1-cycle latency, full throughput); without it the
// data path is combinational from data_i to data_o.
module floo_wormhole_arbiter
  import floo_pkg::*;
#(
  parameter int unsigned NumInp   = 5,
  parameter type         flit_t   = floo_pkg::flit_t,
  parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  floo_wormhole_arbiter_if.slave bus,
  output logic                locked_o,
  output logic [IdxWidth-1:0] gnt_idx_o,
  output arb_state_e          state_o,   // debug: arbiter FSM state
  output logic [IdxWidth-1:0] rr_ptr_o   // debug: round-robin start pointer
);

  localparam logic [IdxWidth:0] NumW = (IdxWidth+1)'(NumInp);

  arb_state_e          state_q, state_d;
  logic [IdxWidth-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;

  logic                any_valid;
  logic [IdxWidth-1:0] sel;
  logic [IdxWidth:0]   cand;
  logic                mux_valid;
  flit_t               mux_data;
  logic                int_ready;  // ready of whatever sits after the mux
  logic                xfer;

  assign locked_o = (state_q == ArbLocked);
  assign state_o  = state_q;
  assign rr_ptr_o = rr_ptr_q;
  assign xfer     = mux_valid & int_ready;

  // Round-robin pick: first valid input scanning upward from rr_ptr_q, modulo NumInp.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
    cand      = '0;
    for (int unsigned off = 0; off < NumInp; off++) begin
      cand = {1'b0, rr_ptr_q} + (IdxWidth+1)'(off);
      if (cand >= NumW) cand = cand - NumW;
      if (bus.valid_i[cand[IdxWidth-1:0]] && !any_valid) begin
        any_valid = 1'b1;
        sel       = cand[IdxWidth-1:0];
      end
    end
  end

  // Mux and ready steering: locked serves only the owner, idle serves the pick.
  // Everything is held quiet while reset is asserted.
  always_comb begin
    mux_valid   = 1'b0;
    mux_data    = '0;
    bus.ready_o = '0;
    gnt_idx_o   = gnt_idx_q;
    if (!rst_i) begin
      if (state_q == ArbLocked) begin
        mux_valid = bus.valid_i[gnt_idx_q];
        if (mux_valid) mux_data = bus.data_i[gnt_idx_q];
        bus.ready_o[gnt_idx_q] = int_ready;
      end else if (any_valid) begin
        mux_valid        = 1'b1;
        mux_data         = bus.data_i[sel];
        bus.ready_o[sel] = int_ready;
        gnt_idx_o        = sel;
      end
    end
  end

  // FSM next state: lock on a non-tail head, release and advance rr on the tail.
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      ArbIdle: begin
        if (xfer) begin
          if (mux_data.hdr.last) begin
            rr_ptr_d = IdxWidth'(rr_next(32'(sel), NumInp));
          end else begin
            state_d   = ArbLocked;
            gnt_idx_d = sel;
          end
        end
      end
      ArbLocked: begin
        if (xfer && mux_data.hdr.last) begin
          state_d  = ArbIdle;
          rr_ptr_d = IdxWidth'(rr_next(32'(gnt_idx_q), NumInp));
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // Arbiter state registers; reset drops any lock and restarts rr at input 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ArbIdle;
      gnt_idx_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

`ifdef FLOO_WORMHOLE_ARB_OUT_REG_EN
  floo_output_reg #(
    .T (flit_t)
  ) i_out_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (mux_valid),
    .ready_o (int_ready),
    .data_i  (mux_data),
    .valid_o (bus.valid_o),
    .ready_i (bus.ready_i),
    .data_o  (bus.data_o)
  );
`else
  assign int_ready   = bus.ready_i;
  assign bus.valid_o = mux_valid;
  assign bus.data_o  = mux_data;
`endif

endmodule
